// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states
// and op-decode helpers used by mdu_iter and mdu_div_core.
package mdu_pkg;

   localparam int unsigned OP_W = 4;

   typedef enum logic [OP_W-1:0] {
      MDU_NOP   = 4'd0,
      MDU_MULT  = 4'd1,
      MDU_MULTU = 4'd2,
      MDU_MADD  = 4'd3,
      MDU_MADDU = 4'd4,
      MDU_MSUB  = 4'd5,
      MDU_MSUBU = 4'd6,
      MDU_DIV   = 4'd7,
      MDU_DIVU  = 4'd8,
      MDU_MTHI  = 4'd9,
      MDU_MTLO  = 4'd10
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_FIX
   } mdu_state_e;

   function automatic logic op_is_valid(input logic [OP_W-1:0] op);
      return (op >= MDU_MULT) && (op <= MDU_MTLO);
   endfunction

   function automatic logic op_is_div(input logic [OP_W-1:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

   function automatic logic op_is_signed(input logic [OP_W-1:0] op);
      return (op == MDU_MULT) || (op == MDU_MADD) || (op == MDU_MSUB) || (op == MDU_DIV);
   endfunction

   function automatic logic op_is_madd(input logic [OP_W-1:0] op);
      return (op == MDU_MADD) || (op == MDU_MADDU);
   endfunction

   function automatic logic op_is_msub(input logic [OP_W-1:0] op);
      return (op == MDU_MSUB) || (op == MDU_MSUBU);
   endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Iterative 1-bit-per-cycle restoring divider on unsigned magnitudes.
// go loads operands; fin is high during the last iteration cycle, so
// quot/rem are valid the cycle after fin. kill aborts immediately.
// Optional: MDU_EARLY_OUT_EN skips the leading zeros of the dividend.
module mdu_div_core
   import mdu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             kill,
   input  logic             go,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem,
   output logic             fin
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_r;
   logic [WIDTH-1:0] r_d;
   logic [CW-1:0]    w_iters;
   logic [WIDTH-1:0] w_dvd_init;
   logic [WIDTH:0]   w_sh;
   logic [WIDTH-1:0] w_sub;
   logic             w_ge;

`ifdef MDU_EARLY_OUT_EN
   // Number of significant bits of v (0 for v == 0).
   function automatic logic [CW-1:0] sig_bits(input logic [WIDTH-1:0] v);
      logic [CW-1:0] n;
      n = '0;
      for (int unsigned i = 0; i < WIDTH; i++)
         if (v[i]) n = CW'(i + 1);
      return n;
   endfunction

   // Iteration count and pre-aligned dividend: the dividend is shifted so its
   // top significant bit sits at the MSB; the quotient still lands in r_q.
   always_comb begin
      w_iters = sig_bits(dividend);
      if (w_iters == '0) w_iters = CW'(1);
      w_dvd_init = dividend << (WIDTH - w_iters);
   end
`else
   // Fixed full-width iteration count.
   always_comb begin
      w_iters    = CW'(WIDTH);
      w_dvd_init = dividend;
   end
`endif

   // One restoring step: shift in the next dividend bit, trial-subtract divisor.
   always_comb begin
      w_sh  = {r_r, r_q[WIDTH-1]};
      w_ge  = (w_sh >= {1'b0, r_d});
      w_sub = w_sh[WIDTH-1:0] - r_d;
   end

   // Operand load and iteration state.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt <= '0;
         r_q   <= '0;
         r_r   <= '0;
         r_d   <= '0;
      end else if (kill) begin
         r_cnt <= '0;
      end else if (go) begin
         r_cnt <= w_iters;
         r_q   <= w_dvd_init;
         r_r   <= '0;
         r_d   <= divisor;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - CW'(1);
         r_q   <= {r_q[WIDTH-2:0], w_ge};
         r_r   <= w_ge ? w_sub : w_sh[WIDTH-1:0];
      end
   end

   // Result and last-iteration flag.
   always_comb begin
      quot = r_q;
      rem  = r_r;
      fin  = (r_cnt == CW'(1));
   end

endmodule

// File: rtl/mdu_iter.sv
// Multiply/divide unit beside the EX-stage ALU. Owns HI/LO.
// Multiplies go through a MUL_LAT-cycle product pipeline; divides use
// mdu_div_core followed by a sign-fix/writeback cycle.
// Optional: MDU_EARLY_OUT_EN (passed through to mdu_div_core).
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned MUL_LAT = 2
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             flush,
   input  logic             start,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] opr1,
   input  logic [WIDTH-1:0] opr2,
   output logic             busy,
   output logic             done,
   output logic             stallreq,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned DW   = 2 * WIDTH;
   localparam int unsigned MCW  = $clog2(MUL_LAT + 1);
   localparam bit          MUL1 = (MUL_LAT == 1);

   mdu_state_e       r_state, w_state_nxt;
   logic [OP_W-1:0]  r_op;
   logic [DW-1:0]    r_prod;
   logic             r_neg;
   logic             r_rneg;
   logic             r_dz;
   logic [WIDTH-1:0] r_dvd_raw;
   logic [MCW-1:0]   r_mcnt;
   logic             r_done;
   logic [WIDTH-1:0] r_hi, r_lo;

   logic             w_accept;
   logic             w_a_neg, w_b_neg;
   logic [WIDTH-1:0] w_mag_a, w_mag_b;
   logic [DW-1:0]    w_prod_now;
   logic [OP_W-1:0]  w_wb_op;
   logic [DW-1:0]    w_wb_mag, w_prod_sgn, w_mul_res;
   logic             w_wb_neg;
   logic             w_wb_mul, w_wb_div, w_wb_mthi, w_wb_mtlo;
   logic [WIDTH-1:0] w_quot, w_rem, w_div_lo, w_div_hi;
   logic             w_fin;

   // Accept decode and operand magnitudes (shared by multiplier and divider).
   always_comb begin
      w_accept   = (r_state == ST_IDLE) && start && !flush && !r_done && op_is_valid(op);
      w_a_neg    = op_is_signed(op) && opr1[WIDTH-1];
      w_b_neg    = op_is_signed(op) && opr2[WIDTH-1];
      w_mag_a    = w_a_neg ? -opr1 : opr1;
      w_mag_b    = w_b_neg ? -opr2 : opr2;
      w_prod_now = DW'(w_mag_a) * DW'(w_mag_b);
   end

   // Multiply writeback: sign the magnitude product, then accumulate on HI/LO.
   // With MUL_LAT == 1 the writeback happens in the accept cycle itself.
   always_comb begin
      w_wb_op    = MUL1 ? op : r_op;
      w_wb_mag   = MUL1 ? w_prod_now : r_prod;
      w_wb_neg   = MUL1 ? (w_a_neg ^ w_b_neg) : r_neg;
      w_prod_sgn = w_wb_neg ? -w_wb_mag : w_wb_mag;
      if (op_is_madd(w_wb_op))      w_mul_res = {r_hi, r_lo} + w_prod_sgn;
      else if (op_is_msub(w_wb_op)) w_mul_res = {r_hi, r_lo} - w_prod_sgn;
      else                          w_mul_res = w_prod_sgn;
   end

   // Divide sign correction and divide-by-zero override.
   always_comb begin
      w_div_lo = r_neg  ? -w_quot : w_quot;
      w_div_hi = r_rneg ? -w_rem  : w_rem;
      if (r_dz) begin
         w_div_lo = '1;
         w_div_hi = r_dvd_raw;
      end
   end

   mdu_div_core #(
      .WIDTH(WIDTH)
   ) u_div (
      .clk      (clk),
      .resetn   (resetn),
      .kill     (flush),
      .go       (w_accept && op_is_div(op)),
      .dividend (w_mag_a),
      .divisor  (w_mag_b),
      .quot     (w_quot),
      .rem      (w_rem),
      .fin      (w_fin)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Next state and writeback strobes; flush overrides everything.
   always_comb begin
      w_state_nxt = r_state;
      w_wb_mul    = 1'b0;
      w_wb_div    = 1'b0;
      w_wb_mthi   = 1'b0;
      w_wb_mtlo   = 1'b0;
      if (flush) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  if (op == MDU_MTHI)      w_wb_mthi = 1'b1;
                  else if (op == MDU_MTLO) w_wb_mtlo = 1'b1;
                  else if (op_is_div(op))  w_state_nxt = ST_DIV;
                  else if (MUL1)           w_wb_mul = 1'b1;
                  else                     w_state_nxt = ST_MUL;
               end
            end
            ST_MUL: begin
               if (r_mcnt == '0) begin
                  w_wb_mul    = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_DIV: begin
               if (w_fin) w_state_nxt = ST_FIX;
            end
            ST_FIX: begin
               w_wb_div    = 1'b1;
               w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Operand latch, multiply stage counter, HI/LO writeback and done pulse.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_op      <= '0;
         r_prod    <= '0;
         r_neg     <= 1'b0;
         r_rneg    <= 1'b0;
         r_dz      <= 1'b0;
         r_dvd_raw <= '0;
         r_mcnt    <= '0;
         r_done    <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
      end else begin
         r_done <= w_wb_mul || w_wb_div || w_wb_mthi || w_wb_mtlo;
         if (w_accept) begin
            r_op      <= op;
            r_prod    <= w_prod_now;
            r_neg     <= w_a_neg ^ w_b_neg;
            r_rneg    <= w_a_neg;
            r_dz      <= (opr2 == '0);
            r_dvd_raw <= opr1;
            r_mcnt    <= MUL1 ? '0 : MCW'(MUL_LAT - 2);
         end else if ((r_state == ST_MUL) && (r_mcnt != '0)) begin
            r_mcnt <= r_mcnt - MCW'(1);
         end
         if (w_wb_mthi) r_hi <= opr1;
         if (w_wb_mtlo) r_lo <= opr1;
         if (w_wb_mul) {r_hi, r_lo} <= w_mul_res;
         if (w_wb_div) begin
            r_hi <= w_div_hi;
            r_lo <= w_div_lo;
         end
      end
   end

   // Outputs.
   always_comb begin
      busy     = (r_state != ST_IDLE);
      done     = r_done;
      stallreq = start && !r_done && !flush;
      hi       = r_hi;
      lo       = r_lo;
   end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised multiply/divide unit placed beside the EX-stage ALU.
- Owns the HI/LO register pair.
- Executes MULT/MULTU/MADD/MADDU/MSUB/MSUBU through a MUL_LAT-stage product pipeline, and DIV/DIVU through an iterative 1-bit-per-cycle restoring divider.
- Level start/done handshake lets EX hold the pipeline stalled. Flush from exception handling aborts an operation cleanly.

Parameters:
- WIDTH, 32: operand width and width of each of HI and LO.
- MUL_LAT, 2: multiply latency in cycles, accept cycle to done. Must be >= 1.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- flush  in  1  abort in-flight op; drop start this cycle
- start  in  1  level request; held high by EX until done
- op  in  4  operation code (mdu_pkg)
- opr1  in  WIDTH  rs operand / dividend / MTHI-MTLO source
- opr2  in  WIDTH  rt operand / divisor
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse; hi/lo hold the new result
- stallreq  out  1  start & ~done & ~flush (combinational)
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async, resetn low): state=IDLE; busy=0, done=0, hi=0, lo=0; counters and datapath registers cleared.
- States:
  - IDLE: accepts start.
  - MUL: counts MUL_LAT-1 cycles.
  - DIV: WIDTH iterations.
  - FIX: sign correction and writeback.
- Accept: in IDLE with start=1, flush=0, op a MDU op. The accept cycle is called N.
- MTHI/MTLO: write opr1 to hi/lo at the end of cycle N. done=1 in N+1. busy never asserts.
- Multiply:
  - Magnitude product of |opr1|*|opr2|; sign applied at the last stage, as for mul_s.
  - MADD/MSUB: {hi,lo} ± product, taken modulo 2*WIDTH, using the hi/lo values at the time of writeback.
  - hi/lo written at the end of cycle N+MUL_LAT-1. done=1 in cycle N+MUL_LAT.
- Divide:
  - Cycle N latches |dividend| and |divisor| plus the quotient and remainder signs.
  - WIDTH iterations follow, then FIX.
  - FIX negates the quotient if the operand signs differ, and negates the remainder if the dividend was negative.
  - done=1 in cycle N+WIDTH+2.
  - Result: lo=quotient, hi=remainder.
- Divide by zero: lo = all ones, hi = dividend (raw opr1). Same latency; no exception raised.
- Signed overflow (-2^(WIDTH-1) / -1): lo = -2^(WIDTH-1), hi = 0.
- busy=1 from N+1 until the cycle done rises. done and busy are never both 1.
- start changes while busy (op, operands) are ignored; latched values are used.
- After done, the unit returns to IDLE. If start is still high the cycle after done, that is a new request. EX must drop start on the done cycle.
- Flush:
  - In any state: next state IDLE, busy=0, no done, hi/lo unchanged. This includes flush in the writeback cycle, which suppresses the write.
  - flush and start in the same IDLE cycle: flush wins, nothing is accepted.
- Reset mid-operation: immediate return to reset values.

Optional Feature:
- MDU_EARLY_OUT_EN defined:
  - Divider skips leading zeros of |dividend|; iteration count = max(1, WIDTH - clz(|dividend|)).
  - Dividend 0 takes 1 iteration.
  - done in cycle N + iterations + 2.
- Undefined: fixed WIDTH iterations.
- Results are identical either way.

Decomposition:
- Shared package mdu_pkg holds:
  - op codes: MDU_MULT=1, MULTU=2, MADD=3, MADDU=4, MSUB=5, MSUBU=6, DIV=7, DIVU=8, MTHI=9, MTLO=10; 0 = no-op.
  - state enum IDLE/MUL/DIV/FIX.
  - helper constants.
- Sub-module mdu_div_core: iterative restoring divider with an internal counter and optional early-out. Ports: clk, resetn, kill, go, dividend, divisor, quot, rem, fin.
- Multiplier pipeline and HI/LO live in the top module.

Test Plan:
- DIVU opr1=100, opr2=7, WIDTH=32 -> done at N+34 (N+9 with MDU_EARLY_OUT_EN); lo=14, hi=2.
- DIV opr1=0xFFFFFFF9 (-7), opr2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- MULT 0xFFFFFFFF x 2 -> done at N+2; hi=0xFFFFFFFF, lo=0xFFFFFFFE. Then MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- MTHI 0, MTLO 0xFFFFFFFF, then MADDU 1x1 -> hi=1, lo=0. Then MSUB 1x1 -> hi=0, lo=0xFFFFFFFF.
- DIVU x/0 and DIV 0x80000000/0xFFFFFFFF -> lo=0xFFFFFFFF, hi=x; then lo=0x80000000, hi=0.
- DIV with flush at N+10, hi/lo preloaded 0x11/0x22 -> busy=0 at N+11, no done pulse, hi=0x11, lo=0x22; stallreq=0 during flush.
